// File: rtl/tx_symbol_serializer_10b.sv
// Serializes 10-bit 8b/10b symbols MSB ('a') first, one bit per bit_en_i strobe.
// A one-entry holding buffer decouples the encoder; the idle/comma symbol fills underruns.
module tx_symbol_serializer_10b #(
  parameter logic [9:0]  IDLE_SYMBOL = 10'h0FA,
  parameter int unsigned UNDERRUN_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_en_i,
  input  logic                  bit_en_i,
  input  logic [9:0]            symbol_i,
  input  logic                  symbol_valid_i,
  output logic                  symbol_ready_o,
  output logic                  serial_o,
  output logic                  symbol_start_o,
  output logic                  busy_o,
  output logic                  underrun_o,
  output logic [UNDERRUN_W-1:0] underrun_cnt_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t     state_q;
  logic [9:0] hold_q;
  logic       hold_vld_q;
  logic [8:0] shift_q;
  logic [3:0] bit_cnt_q;

  logic       load;
  logic       accept;
  logic       last_bit;
  logic [9:0] load_src;

  always_comb begin
    last_bit       = (bit_cnt_q == 4'd9);
    load           = bit_en_i & tx_en_i &
                     ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & last_bit));
    load_src       = hold_vld_q ? hold_q : IDLE_SYMBOL;
    // A load frees the buffer in the same cycle, so a new symbol can follow with no bubble
    symbol_ready_o = ~hold_vld_q | load;
    accept         = symbol_valid_i & symbol_ready_o;
  end

  assign busy_o = (state_q == ST_SHIFT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (accept) begin
      hold_q     <= symbol_i;
      hold_vld_q <= 1'b1;
    end else if (load) begin
      hold_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      serial_o       <= 1'b0;
      symbol_start_o <= 1'b0;
      underrun_o     <= 1'b0;
      underrun_cnt_o <= '0;
    end else begin
      underrun_o <= 1'b0;
      if (load) begin
        state_q        <= ST_SHIFT;
        serial_o       <= load_src[9];
        shift_q        <= load_src[8:0];
        bit_cnt_q      <= '0;
        symbol_start_o <= 1'b1;
        if (!hold_vld_q) begin
          underrun_o <= 1'b1;
          if (underrun_cnt_o != '1) begin
            underrun_cnt_o <= underrun_cnt_o + UNDERRUN_W'(1);
          end
        end
      end else if ((state_q == ST_SHIFT) && bit_en_i) begin
        symbol_start_o <= 1'b0;
        if (!last_bit) begin
          serial_o  <= shift_q[8];
          shift_q   <= {shift_q[7:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end else begin
          // Symbol finished with tx disabled: park the line low
          state_q  <= ST_IDLE;
          serial_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_symbol_serializer_10b.sv
// Directed self-checking bench for tx_symbol_serializer_10b.
module tb_tx_symbol_serializer_10b;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tx_en_i;
  logic        bit_en_i;
  logic [9:0]  symbol_i;
  logic        symbol_valid_i;
  logic        symbol_ready_o;
  logic        serial_o;
  logic        symbol_start_o;
  logic        busy_o;
  logic        underrun_o;
  logic [15:0] underrun_cnt_o;

  logic        ready2, serial2, start2, busy2, underrun2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tx_symbol_serializer_10b u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_en_i(tx_en_i), .bit_en_i(bit_en_i),
    .symbol_i(symbol_i), .symbol_valid_i(symbol_valid_i), .symbol_ready_o(symbol_ready_o),
    .serial_o(serial_o), .symbol_start_o(symbol_start_o), .busy_o(busy_o),
    .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o)
  );

  tx_symbol_serializer_10b #(.UNDERRUN_W(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .tx_en_i(tx_en_i), .bit_en_i(bit_en_i),
    .symbol_i(symbol_i), .symbol_valid_i(symbol_valid_i), .symbol_ready_o(ready2),
    .serial_o(serial2), .symbol_start_o(start2), .busy_o(busy2),
    .underrun_o(underrun2), .underrun_cnt_o(cnt2)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    tx_en_i = 1'b0; bit_en_i = 1'b0; symbol_i = '0; symbol_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tx_en_i = 1'b1; bit_en_i = 1'b1; symbol_i = '0; symbol_valid_i = 1'b0;
    tick();
    checks++;
    if ({serial_o, symbol_start_o, busy_o, underrun_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {serial_o, symbol_start_o, busy_o, underrun_o});
    end
    checks++;
    if (underrun_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", underrun_cnt_o);
    end
    checks++;
    if (symbol_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", symbol_ready_o);
    end
    rst_i = 1'b0;
    tx_en_i = 1'b0; bit_en_i = 1'b0;
    #1;
  endtask

  task automatic test_idle_fill();
    logic [9:0] idle_sym = 10'h0FA;
    do_reset();
    tx_en_i = 1'b1; bit_en_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (serial_o !== idle_sym[9 - (k % 10)]) begin
        errors++; $display("FAIL idle_serial k=%0d got %b want %b", k, serial_o, idle_sym[9 - (k % 10)]);
      end
      checks++;
      if (underrun_o !== (k % 10 == 0) || symbol_start_o !== (k % 10 == 0)) begin
        errors++; $display("FAIL idle_pulse k=%0d underrun %b start %b want %b", k, underrun_o, symbol_start_o, (k % 10 == 0));
      end
      checks++;
      if (busy_o !== 1'b1) begin
        errors++; $display("FAIL idle_busy k=%0d got %b want 1", k, busy_o);
      end
    end
    checks++;
    if (underrun_cnt_o !== 16'd2) begin
      errors++; $display("FAIL idle_cnt got %0d want 2", underrun_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] sa = 10'h2AB;
    logic [9:0] sb = 10'h154;
    logic [9:0] cur;
    do_reset();
    bit_en_i = 1'b1; symbol_valid_i = 1'b1; symbol_i = sa;
    #1;
    checks++;
    if (symbol_ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_empty got %b want 1", symbol_ready_o);
    end
    tick();
    symbol_i = sb;
    #1;
    checks++;
    if (symbol_ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_full got %b want 0", symbol_ready_o);
    end
    tx_en_i = 1'b1;
    #1;
    checks++;
    if (symbol_ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_load got %b want 1", symbol_ready_o);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) symbol_valid_i = 1'b0;
      cur = (k < 10) ? sa : sb;
      checks++;
      if (serial_o !== cur[9 - (k % 10)]) begin
        errors++; $display("FAIL b2b_serial k=%0d got %b want %b", k, serial_o, cur[9 - (k % 10)]);
      end
      checks++;
      if (symbol_start_o !== (k == 0 || k == 10) || underrun_o !== 1'b0) begin
        errors++; $display("FAIL b2b_start k=%0d start %b underrun %b want start %b underrun 0", k, symbol_start_o, underrun_o, (k == 0 || k == 10));
      end
    end
  endtask

  task automatic test_slow_strobe();
    logic [9:0] s = 10'h3E0;
    do_reset();
    tx_en_i = 1'b1; symbol_valid_i = 1'b1; symbol_i = s;
    tick();
    symbol_valid_i = 1'b0;
    #1;
    checks++;
    if (symbol_ready_o !== 1'b0) begin
      errors++; $display("FAIL slow_ready_held got %b want 0", symbol_ready_o);
    end
    tick();
    checks++;
    if (symbol_ready_o !== 1'b0 || busy_o !== 1'b0 || serial_o !== 1'b0) begin
      errors++; $display("FAIL slow_wait ready %b busy %b serial %b want 0 0 0", symbol_ready_o, busy_o, serial_o);
    end
    bit_en_i = 1'b1;
    #1;
    checks++;
    if (symbol_ready_o !== 1'b1) begin
      errors++; $display("FAIL slow_ready_load got %b want 1", symbol_ready_o);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      bit_en_i = ((c + 1) % 4 == 0);
      checks++;
      if (serial_o !== s[9 - (c / 4)] || symbol_start_o !== (c < 4)) begin
        errors++; $display("FAIL slow_serial c=%0d serial %b start %b want %b %b", c, serial_o, symbol_start_o, s[9 - (c / 4)], (c < 4));
      end
    end
  endtask

  task automatic test_tx_disable();
    logic [9:0] sa = 10'h2AB;
    logic [9:0] sb = 10'h355;
    do_reset();
    bit_en_i = 1'b1; symbol_valid_i = 1'b1; symbol_i = sa;
    tick();
    symbol_valid_i = 1'b0; tx_en_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin symbol_valid_i = 1'b1; symbol_i = sb; end
      if (k == 1) symbol_valid_i = 1'b0;
      if (k == 4) tx_en_i = 1'b0;
      checks++;
      if (serial_o !== sa[9 - k] || busy_o !== 1'b1 || underrun_o !== 1'b0) begin
        errors++; $display("FAIL dis_serial k=%0d serial %b busy %b underrun %b want %b 1 0", k, serial_o, busy_o, underrun_o, sa[9 - k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (serial_o !== 1'b0 || busy_o !== 1'b0 || symbol_start_o !== 1'b0) begin
        errors++; $display("FAIL dis_idle k=%0d serial %b busy %b start %b want 0 0 0", k, serial_o, busy_o, symbol_start_o);
      end
    end
    checks++;
    if (symbol_ready_o !== 1'b0) begin
      errors++; $display("FAIL dis_hold_kept ready %b want 0", symbol_ready_o);
    end
    tx_en_i = 1'b1;
    tick();
    checks++;
    if (serial_o !== sb[9] || symbol_start_o !== 1'b1 || underrun_o !== 1'b0) begin
      errors++; $display("FAIL dis_resume serial %b start %b underrun %b want %b 1 0", serial_o, symbol_start_o, underrun_o, sb[9]);
    end
    tick();
    checks++;
    if (serial_o !== sb[8]) begin
      errors++; $display("FAIL dis_resume_bit8 got %b want %b", serial_o, sb[8]);
    end
  endtask

  task automatic test_underrun_sat();
    int n;
    logic [1:0] exp2;
    do_reset();
    tx_en_i = 1'b1; bit_en_i = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (k % 10 == 0) begin
        n = k / 10 + 1;
        exp2 = (n > 3) ? 2'd3 : 2'(n);
        checks++;
        if (cnt2 !== exp2 || underrun2 !== 1'b1) begin
          errors++; $display("FAIL sat_cnt2 load=%0d got %0d pulse %b want %0d 1", n, cnt2, underrun2, exp2);
        end
        checks++;
        if (underrun_cnt_o !== 16'(n)) begin
          errors++; $display("FAIL sat_cnt16 load=%0d got %0d want %0d", n, underrun_cnt_o, n);
        end
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    logic [9:0] s = 10'h3E0;
    do_reset();
    tx_en_i = 1'b1; bit_en_i = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (serial_o !== 1'b1 || underrun_cnt_o !== 16'd1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_pre serial %b cnt %0d busy %b want 1 1 1", serial_o, underrun_cnt_o, busy_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({serial_o, symbol_start_o, busy_o, underrun_o} !== 4'b0000 || underrun_cnt_o !== 16'd0 || symbol_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_async outs %b cnt %0d ready %b want 0000 0 1", {serial_o, symbol_start_o, busy_o, underrun_o}, underrun_cnt_o, symbol_ready_o);
    end
    tick();
    rst_i = 1'b0; tx_en_i = 1'b0; symbol_valid_i = 1'b1; symbol_i = s;
    tick();
    symbol_valid_i = 1'b0; tx_en_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (serial_o !== s[9 - k] || symbol_start_o !== (k == 0) || underrun_o !== 1'b0) begin
        errors++; $display("FAIL rst_post k=%0d serial %b start %b underrun %b want %b %b 0", k, serial_o, symbol_start_o, underrun_o, s[9 - k], (k == 0));
      end
    end
    checks++;
    if (underrun_cnt_o !== 16'd0) begin
      errors++; $display("FAIL rst_post_cnt got %0d want 0", underrun_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_idle_fill();
    test_back_to_back();
    test_slow_strobe();
    test_tx_disable();
    test_underrun_sat();
    test_reset_mid_symbol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
